dh_modexp_sched: RTL and testbench

Shared modular-exponentiation scheduler for the Diffie-Hellman key-exchange datapath. Two requesters (party A and party B, or public-key and shared-key stages) submit base/exponent pairs against a common modulus. The block arbitrates round-robin and sequences one iterative square-and-multiply engine, one exponent bit per cycle. It returns `base**exp mod p` to the granted requester. It replaces per-party combinational `**`/divide logic with one bounded, multi-cycle resource.

---
 rtl/dh_pkg.sv | 14 +
 rtl/dh_modmul_step.sv | 34 +++
 rtl/dh_modexp_sched.sv | 106 ++++++++++
 tb/tb_dh_modexp_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// Shared types and defaults for the Diffie-Hellman modular-exponentiation scheduler.
package dh_pkg;
  localparam int DEF_W     = 32;
  localparam int DEF_EXP_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic req_idx_t;
endpackage

// File: rtl/dh_modmul_step.sv
// One square-and-multiply step: acc^2 mod p, then times base mod p when the exponent bit is set.
module dh_modmul_step
  import dh_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] base,
  input  logic [W-1:0] p,
  input  logic         exp_bit,
  output logic [W-1:0] next_acc
);
  logic [2*W-1:0] divisor;
  logic [2*W-1:0] sq_full;
  logic [2*W-1:0] sq_red;
  logic [2*W-1:0] mul_full;
  logic [2*W-1:0] mul_red;

  // A zero modulus never reaches the dividers; the step result is forced to 0 instead.
  always_comb begin
    divisor  = (p == '0) ? (2*W)'(1) : {{W{1'b0}}, p};
    sq_full  = {{W{1'b0}}, acc} * {{W{1'b0}}, acc};
    sq_red   = sq_full % divisor;
    mul_full = sq_red * {{W{1'b0}}, base};
    mul_red  = mul_full % divisor;
    if (p == '0) begin
      next_acc = '0;
    end else if (exp_bit) begin
      next_acc = W'(mul_red);
    end else begin
      next_acc = W'(sq_red);
    end
  end
endmodule

// File: rtl/dh_modexp_sched.sv
// Round-robin arbiter plus one iterative modexp engine shared by two requesters.
module dh_modexp_sched
  import dh_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     p,
  input  logic             req0,
  input  logic             req1,
  input  logic [W-1:0]     base0,
  input  logic [W-1:0]     base1,
  input  logic [EXP_W-1:0] exp0,
  input  logic [EXP_W-1:0] exp1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [W-1:0]     result,
  output logic             err,
  output logic             busy,
  output state_t           state
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

  // Handshake: reqN is a level held with stable operands until ackN; ackN is a
  // one-cycle pulse in GRANT, and rspValidN pulses once in DONE for that job.
  state_t          cur_state, next_state;
  req_idx_t        owner, last, winner;
  logic [W-1:0]    base_q, p_q, acc, step_acc, result_q;
  logic [EXP_W-1:0] exp_q;
  logic [IDX_W-1:0] idx;

  dh_modmul_step #(.W(W)) u_step (
    .acc     (acc),
    .base    (base_q),
    .p       (p_q),
    .exp_bit (exp_q[idx]),
    .next_acc(step_acc)
  );

  // Contention goes to the requester not served last; a lone request always wins.
  always_comb begin
    winner = (req0 && req1) ? ~last : req1;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (req0 || req1) next_state = GRANT;
      GRANT:   next_state = RUN;
      RUN:     if (idx == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      base_q    <= '0;
      exp_q     <= '0;
      p_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      result_q  <= '0;
    end else begin
      cur_state <= next_state;
      case (cur_state)
        IDLE: begin
          if (req0 || req1) owner <= winner;
        end
        GRANT: begin
          base_q <= owner ? base1 : base0;
          exp_q  <= owner ? exp1 : exp0;
          p_q    <= p;
          acc    <= W'(1);
          idx    <= IDX_TOP;
        end
        RUN: begin
          acc <= step_acc;
          idx <= idx - IDX_W'(1);
          if (idx == '0) result_q <= step_acc;
        end
        DONE: begin
          last <= owner;
        end
        default: ;
      endcase
    end
  end

  assign ack0       = (cur_state == GRANT) && (owner == 1'b0);
  assign ack1       = (cur_state == GRANT) && (owner == 1'b1);
  assign rsp_valid0 = (cur_state == DONE) && (owner == 1'b0);
  assign rsp_valid1 = (cur_state == DONE) && (owner == 1'b1);
  assign err        = (cur_state == DONE) && (p_q == '0);
  assign busy       = (cur_state != IDLE);
  assign result     = result_q;
  assign state      = cur_state;
endmodule

// File: tb/tb_dh_modexp_sched.sv
// Self-checking bench for dh_modexp_sched: vector table, directed arbitration/reset sequences, result scoreboard.
module tb_dh_modexp_sched;
  import dh_pkg::*;

  localparam int W     = 32;
  localparam int EXP_W = 32;
  localparam int LAT   = EXP_W + 2;

  logic             clk;
  logic             rst;
  logic [W-1:0]     p;
  logic             req0, req1;
  logic [W-1:0]     base0, base1;
  logic [EXP_W-1:0] exp0, exp1;
  logic             ack0, ack1, rsp_valid0, rsp_valid1, err, busy;
  logic [W-1:0]     result;
  state_t           state;

  dh_modexp_sched #(.W(W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .req0      (req0),
    .req1      (req1),
    .base0     (base0),
    .base1     (base1),
    .exp0      (exp0),
    .exp1      (exp1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rsp_valid0(rsp_valid0),
    .rsp_valid1(rsp_valid1),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             sel;
    logic [W-1:0]     base;
    logic [EXP_W-1:0] expo;
    logic [W-1:0]     p;
    logic [W-1:0]     res;
    logic             err;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] sb_e;
  req_idx_t    tb_last;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Right-to-left reference exponentiation.
  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [EXP_W-1:0] e,
                                         input logic [W-1:0] m);
    logic [63:0] r, x, mm;
    if (m == '0) return '0;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    for (int i = 0; i < EXP_W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[W-1:0];
  endfunction

  // Scoreboard: every completion pops {owner, err, result}.
  always @(negedge clk) begin
    if (rst && (rsp_valid0 || rsp_valid1)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got owner=%0d result=%0h with nothing expected", rsp_valid1, result);
      end else begin
        sb_e = exp_q.pop_front();
        check("rsp", {rsp_valid1, err, result}, sb_e);
      end
    end
    if (rst && (32'(ack0) + 32'(ack1) + 32'(rsp_valid0) + 32'(rsp_valid1) > 1)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL exclusive: got ack=%b%b rsp=%b%b required at most one", ack1, ack0, rsp_valid1, rsp_valid0);
    end
  end

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic do_job(input logic sel, input logic [W-1:0] b, input logic [EXP_W-1:0] e,
                        input logic [W-1:0] pp, input logic [W-1:0] res, input logic er);
    int cyc;
    bit got_ack, done;
    exp_q.push_back({sel, er, res});
    @(posedge clk);
    #1;
    p = pp;
    if (sel) begin base1 = b; exp1 = e; req1 = 1'b1; end
    else     begin base0 = b; exp0 = e; req0 = 1'b1; end
    cyc = 0; got_ack = 0; done = 0;
    while (!done && cyc < LAT + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((sel ? ack1 : ack0) && !got_ack) begin
        got_ack = 1;
        check("ack_lat", 64'(cyc), 64'd1);
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (sel ? rsp_valid1 : rsp_valid0) begin
        check("rsp_lat", 64'(cyc), 64'(LAT));
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL job_timeout: got no rsp_valid%0d after %0d cycles, required one at %0d", sel, cyc, LAT);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tb_last = sel;
  endtask

  // Both requesters held high until each has its share of n grants.
  task automatic multi_job(input int n, input logic [W-1:0] b0, input logic [EXP_W-1:0] e0,
                           input logic [W-1:0] b1, input logic [EXP_W-1:0] e1,
                           input logic [W-1:0] pp, input logic [W-1:0] r0, input logic [W-1:0] r1);
    logic first, owner;
    int q0, q1, acks, rsps, idle, cyc;
    first = ~tb_last;
    q0 = 0; q1 = 0; acks = 0; rsps = 0; idle = 0; cyc = 0;
    for (int j = 0; j < n; j++) begin
      owner = first ^ j[0];
      exp_q.push_back({owner, 1'b0, owner ? r1 : r0});
      if (owner) q1++; else q0++;
    end
    @(posedge clk);
    #1;
    p = pp; base0 = b0; exp0 = e0; base1 = b1; exp1 = e1;
    req0 = (q0 > 0);
    req1 = (q1 > 0);
    while (rsps < n && cyc < n * (EXP_W + 3) + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack0 || ack1) begin
        check("ack_order", 64'(ack1), 64'(first ^ acks[0]));
        acks++;
        if (ack0) begin q0--; if (q0 <= 0) req0 = 1'b0; end
        else      begin q1--; if (q1 <= 0) req1 = 1'b0; end
      end
      if (rsp_valid0 || rsp_valid1) rsps++;
      else if (!busy && acks > 0) idle++;
    end
    if (rsps < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL multi_timeout: got %0d responses, required %0d", rsps, n);
    end
    check("idle_gaps", 64'(idle), 64'(n - 1));
    req0 = 1'b0;
    req1 = 1'b0;
    tb_last = first ^ 1'((n - 1) % 2);
  endtask

  initial begin
    logic             rs;
    logic [W-1:0]     rb, rp;
    logic [EXP_W-1:0] re;
    int               wait_cyc;

    vecs[0] = '{1'b0, 32'd5,     32'd6,  32'd23, 32'd8,  1'b0};
    vecs[1] = '{1'b1, 32'd19,    32'd6,  32'd23, 32'd2,  1'b0};
    vecs[2] = '{1'b0, 32'd8,     32'd15, 32'd23, 32'd2,  1'b0};
    vecs[3] = '{1'b1, 32'd7,     32'd0,  32'd23, 32'd1,  1'b0};
    vecs[4] = '{1'b0, 32'd12345, 32'd99, 32'd1,  32'd0,  1'b0};
    vecs[5] = '{1'b1, 32'd5,     32'd6,  32'd0,  32'd0,  1'b1};
    vecs[6] = '{1'b0, 32'd30,    32'd3,  32'd23, 32'd21, 1'b0};
    vecs[7] = '{1'b1, 32'd2,     32'd10, 32'd1000, 32'd24, 1'b0};

    req0 = 1'b0; req1 = 1'b0; p = '0;
    base0 = '0; base1 = '0; exp0 = '0; exp1 = '0;
    apply_reset();

    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_rsp0", 64'(rsp_valid0), 64'd0);
    check("rst_rsp1", 64'(rsp_valid1), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state), 64'(IDLE));

    // Simultaneous requests straight after reset: requester 0 first.
    multi_job(2, 32'd5, 32'd6, 32'd5, 32'd15, 32'd23, 32'd8, 32'd19);
    // Shared-key pair.
    multi_job(2, 32'd19, 32'd6, 32'd8, 32'd15, 32'd23, 32'd2, 32'd2);

    for (int i = 0; i < 8; i++) begin
      do_job(vecs[i].sel, vecs[i].base, vecs[i].expo, vecs[i].p, vecs[i].res, vecs[i].err);
    end

    for (int i = 0; i < 4; i++) begin
      rs = 1'($urandom_range(0, 1));
      rb = $urandom;
      re = $urandom;
      rp = $urandom_range(2, 32'hFFFF_FFFF);
      do_job(rs, rb, re, rp, model(rb, re, rp), 1'b0);
    end

    // Fairness under continuous contention.
    multi_job(6, 32'd3, 32'd7, 32'd4, 32'd9, 32'd101, model(32'd3, 32'd7, 32'd101),
              model(32'd4, 32'd9, 32'd101));

    // Abort mid-RUN: no response may follow.
    @(posedge clk);
    #1;
    p = 32'd23; base0 = 32'd5; exp0 = 32'd6; req0 = 1'b1;
    wait_cyc = 0;
    while (!ack0 && wait_cyc < 10) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    check("abort_ack_seen", 64'(ack0), 64'd1);
    req0 = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_ack0", 64'(ack0), 64'd0);
    check("abort_rsp0", 64'(rsp_valid0), 64'd0);
    check("abort_rsp1", 64'(rsp_valid1), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(state), 64'(IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tb_last = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("abort_idle", 64'(busy), 64'd0);

    // Pointer reinitialised: requester 0 wins again.
    multi_job(2, 32'd5, 32'd6, 32'd5, 32'd15, 32'd23, 32'd8, 32'd19);
    do_job(1'b1, 32'd5, 32'd15, 32'd23, 32'd19, 1'b0);

    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
